execute_muldiv: RTL and testbench

EXECUTE_MULDIV -- requirements
Module: execute_muldiv

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_step.sv | 62 ++++++
 rtl/execute_muldiv.sv | 209 ++++++++++++++++++++
 tb/tb_execute_muldiv.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension execute unit.
//
// Contents:
//   muldivOp_e     - funct3 encodings of the eight M-extension operations
//   muldivState_e  - IDLE / BUSY / DONE sequencing states
//   ECAUSE_ILLEGAL - exception cause reported alongside exception_out
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldivOp_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldivState_e;

  localparam logic [3:0] ECAUSE_ILLEGAL = 4'd2;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the shared multiply/divide datapath.
//
// The {hi, lo} pair is a double-width working register:
//   multiply: lo holds the remaining multiplier bits, hi the partial sum;
//             conditionally add b to hi, then shift the pair right by one.
//   divide:   lo holds the remaining dividend bits (becoming the quotient),
//             hi the partial remainder; shift left by one and do a
//             restoring trial subtract of b.
//
// Ports:
//   isDiv_i - select restoring-divide step (only with EXECUTE_MULDIV_DIV_EN)
//   hi_i    - upper half of the working register
//   lo_i    - lower half of the working register
//   b_i     - multiplicand / divisor magnitude
//   hi_o    - updated upper half
//   lo_o    - updated lower half
//
// Macro EXECUTE_MULDIV_DIV_EN adds the divide path; without it only the
// shift-add step exists.
module muldiv_step #(
  parameter int XLEN = 32
) (
`ifdef EXECUTE_MULDIV_DIV_EN
  input  logic            isDiv_i,
`endif
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  // Partial sum keeps the carry so the right shift brings it into hi.
  logic [XLEN:0] sum;
  assign sum = {1'b0, hi_i} + {1'b0, (lo_i[0] ? b_i : {XLEN{1'b0}})};

`ifdef EXECUTE_MULDIV_DIV_EN
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            fits;

  // The partial remainder is always below b, so after a successful
  // subtract the difference fits in XLEN bits and modulo arithmetic holds.
  assign shifted = {hi_i, lo_i[XLEN-1]};
  assign fits    = (shifted >= {1'b0, b_i});
  assign diff    = shifted[XLEN-1:0] - b_i;

  always_comb begin
    if (isDiv_i) begin
      hi_o = fits ? diff : shifted[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], fits};
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end
`else
  assign hi_o = sum[XLEN:1];
  assign lo_o = {sum[0], lo_i[XLEN-1:1]};
`endif

endmodule

// File: rtl/execute_muldiv.sv
// Iterative M-extension multiply/divide execute unit.
//
// Operands are converted to magnitudes on accept, STEP_BITS radix-2 steps
// run per BUSY cycle, and one final BUSY cycle applies sign correction and
// selects the high/low half before the result is registered into DONE.
// Divide-by-zero, signed overflow and (without the divider) illegal divide
// ops load a zero count so they finish one edge after accept.
//
// Ports:
//   clk, reset_n              - clock, asynchronous active-low reset
//   req_valid / req_ready     - request handshake from decode
//   op_in                     - funct3 operation select
//   operand_a_in/operand_b_in - rs1 / rs2 values
//   rd_address_in             - destination register
//   stall                     - hold the result in DONE
//   invalidate                - abort any operation and return to IDLE
//   result_valid, result_out  - registered result
//   rd_address_out            - destination of the result
//   exception_out             - illegal instruction (cause ECAUSE_ILLEGAL)
//
// Macro EXECUTE_MULDIV_DIV_EN enables the divider (ops 4-7); otherwise
// those ops raise exception_out with a zero result.
module execute_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      op_in,
  input  logic [XLEN-1:0] operand_a_in,
  input  logic [XLEN-1:0] operand_b_in,
  input  logic [4:0]      rd_address_in,
  input  logic            stall,
  input  logic            invalidate,
  output logic            result_valid,
  output logic [XLEN-1:0] result_out,
  output logic [4:0]      rd_address_out,
  output logic            exception_out
);

  localparam int N  = XLEN / STEP_BITS;
  localparam int CW = $clog2(N + 1);

  muldivState_e    state_q;
  muldivOp_e       op_q;
  logic [XLEN-1:0] accHi_q, accLo_q, divisor_q;
  logic [CW-1:0]   count_q;
  logic            negate_q, illegal_q;
  logic [4:0]      rd_q, rdOut_q;
  logic            valid_q, exc_q;
  logic [XLEN-1:0] result_q;

  // Request decode: which operands are signed and their magnitudes.
  muldivOp_e       reqOp;
  logic            aSigned, bSigned, aNeg, bNeg, isDivReq;
  logic [XLEN-1:0] aMag, bMag;

  assign reqOp    = muldivOp_e'(op_in);
  assign isDivReq = op_in[2];
  assign aSigned  = (reqOp == OP_MULH) || (reqOp == OP_MULHSU) ||
                    (reqOp == OP_DIV)  || (reqOp == OP_REM);
  assign bSigned  = (reqOp == OP_MULH) || (reqOp == OP_DIV) || (reqOp == OP_REM);
  assign aNeg     = aSigned & operand_a_in[XLEN-1];
  assign bNeg     = bSigned & operand_b_in[XLEN-1];
  assign aMag     = aNeg ? -operand_a_in : operand_a_in;
  assign bMag     = bNeg ? -operand_b_in : operand_b_in;

`ifdef EXECUTE_MULDIV_DIV_EN
  logic divByZero, signedOverflow;
  assign divByZero      = isDivReq && (operand_b_in == '0);
  assign signedOverflow = isDivReq && !op_in[0] &&
                          (operand_a_in == {1'b1, {(XLEN-1){1'b0}}}) &&
                          (operand_b_in == '1);
`endif

  // Combinational chain of STEP_BITS iterations evaluated each BUSY cycle.
  logic [STEP_BITS:0][XLEN-1:0] chainHi, chainLo;
  assign chainHi[0] = accHi_q;
  assign chainLo[0] = accLo_q;

  for (genvar g = 0; g < STEP_BITS; g++) begin : gStep
    muldiv_step #(.XLEN(XLEN)) uStep (
`ifdef EXECUTE_MULDIV_DIV_EN
      .isDiv_i (op_q[2]),
`endif
      .hi_i    (chainHi[g]),
      .lo_i    (chainLo[g]),
      .b_i     (divisor_q),
      .hi_o    (chainHi[g+1]),
      .lo_o    (chainLo[g+1])
    );
  end

  // Sign correction of the magnitude result and half selection.
  logic [2*XLEN-1:0] product, productFixed;
  logic [XLEN-1:0]   finalResult;
  assign product      = {accHi_q, accLo_q};
  assign productFixed = negate_q ? -product : product;

  always_comb begin
    finalResult = '0;
    case (op_q)
      OP_MUL:                       finalResult = productFixed[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: finalResult = productFixed[2*XLEN-1:XLEN];
`ifdef EXECUTE_MULDIV_DIV_EN
      OP_DIV, OP_DIVU:              finalResult = negate_q ? -accLo_q : accLo_q;
      OP_REM, OP_REMU:              finalResult = negate_q ? -accHi_q : accHi_q;
`endif
      default:                      finalResult = '0;
    endcase
  end

  // Sequencer. Invalidate overrides accept and stall; outputs are only
  // non-zero while in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      accHi_q   <= '0;
      accLo_q   <= '0;
      divisor_q <= '0;
      count_q   <= '0;
      negate_q  <= 1'b0;
      illegal_q <= 1'b0;
      rd_q      <= '0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      rdOut_q   <= '0;
      exc_q     <= 1'b0;
    end else if (invalidate) begin
      state_q  <= IDLE;
      count_q  <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      rdOut_q  <= '0;
      exc_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q   <= BUSY;
            op_q      <= reqOp;
            rd_q      <= rd_address_in;
            divisor_q <= bMag;
            accHi_q   <= '0;
            accLo_q   <= aMag;
            count_q   <= CW'(N);
            negate_q  <= (reqOp == OP_REM) ? aNeg : (aNeg ^ bNeg);
            illegal_q <= 1'b0;
`ifdef EXECUTE_MULDIV_DIV_EN
            // Preload the architected special results so the final cycle
            // passes them through unchanged.
            if (divByZero) begin
              accHi_q  <= operand_a_in;
              accLo_q  <= '1;
              count_q  <= '0;
              negate_q <= 1'b0;
            end else if (signedOverflow) begin
              accHi_q  <= '0;
              accLo_q  <= operand_a_in;
              count_q  <= '0;
              negate_q <= 1'b0;
            end
`else
            if (isDivReq) begin
              illegal_q <= 1'b1;
              count_q   <= '0;
            end
`endif
          end
        end
        BUSY: begin
          if (count_q != '0) begin
            accHi_q <= chainHi[STEP_BITS];
            accLo_q <= chainLo[STEP_BITS];
            count_q <= count_q - CW'(1);
          end else begin
            state_q  <= DONE;
            valid_q  <= 1'b1;
            result_q <= illegal_q ? '0 : finalResult;
            exc_q    <= illegal_q;
            rdOut_q  <= rd_q;
          end
        end
        DONE: begin
          if (!stall) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            rdOut_q  <= '0;
            exc_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign result_valid   = valid_q;
  assign result_out     = result_q;
  assign rd_address_out = rdOut_q;
  assign exception_out  = exc_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Testbench for execute_muldiv: one STEP_BITS=1 instance and one
// STEP_BITS=4 instance share the stimulus; a scoreboard of expected
// results (from a behavioural reference model) is filled when a request is
// driven and drained when result_valid rises. Division checks follow the
// EXECUTE_MULDIV_DIV_EN build setting.
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        reqValid = 1'b0;
  logic        stall = 1'b0;
  logic        invalidate = 1'b0;
  logic        useFour = 1'b0;
  logic [2:0]  opIn = '0;
  logic [31:0] aIn = '0;
  logic [31:0] bIn = '0;
  logic [4:0]  rdIn = '0;

  logic        ready1, valid1, exc1, ready4, valid4, exc4;
  logic [31:0] result1, result4;
  logic [4:0]  rdOut1, rdOut4;

  logic        curReady, curValid, curExc;
  logic [31:0] curResult;
  logic [4:0]  curRd;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string       tag;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        exc;
    int          latency;
  } expect_t;

  expect_t sbQueue[$];

  always #5 clk = ~clk;

  execute_muldiv #(.XLEN(32), .STEP_BITS(1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (reqValid & ~useFour),
    .req_ready      (ready1),
    .op_in          (opIn),
    .operand_a_in   (aIn),
    .operand_b_in   (bIn),
    .rd_address_in  (rdIn),
    .stall          (stall),
    .invalidate     (invalidate),
    .result_valid   (valid1),
    .result_out     (result1),
    .rd_address_out (rdOut1),
    .exception_out  (exc1)
  );

  execute_muldiv #(.XLEN(32), .STEP_BITS(4)) dut4 (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (reqValid & useFour),
    .req_ready      (ready4),
    .op_in          (opIn),
    .operand_a_in   (aIn),
    .operand_b_in   (bIn),
    .rd_address_in  (rdIn),
    .stall          (stall),
    .invalidate     (invalidate),
    .result_valid   (valid4),
    .result_out     (result4),
    .rd_address_out (rdOut4),
    .exception_out  (exc4)
  );

  assign curReady  = useFour ? ready4  : ready1;
  assign curValid  = useFour ? valid4  : valid1;
  assign curExc    = useFour ? exc4    : exc1;
  assign curResult = useFour ? result4 : result1;
  assign curRd     = useFour ? rdOut4  : rdOut1;

  // Behavioural reference using native 64-bit arithmetic.
  function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Called on a falling edge; drives one request, returns on the falling
  // edge after the accept edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd,
                               input string tag, input bit track);
    expect_t e;
    int      normalLat;
    normalLat = (useFour ? 8 : 32) + 1;
    if (track) begin
      e.tag = tag;
      e.rd  = rd;
`ifdef EXECUTE_MULDIV_DIV_EN
      e.result  = refResult(op, a, b);
      e.exc     = 1'b0;
      e.latency = (op[2] && (b == 32'd0 ||
                  (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 1 : normalLat;
`else
      if (op[2]) begin
        e.result  = 32'd0;
        e.exc     = 1'b1;
        e.latency = 1;
      end else begin
        e.result  = refResult(op, a, b);
        e.exc     = 1'b0;
        e.latency = normalLat;
      end
`endif
      sbQueue.push_back(e);
    end
    opIn     = op;
    aIn      = a;
    bIn      = b;
    rdIn     = rd;
    reqValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
  endtask

  task automatic waitResult(output int cycles);
    cycles = 0;
    while (!curValid && cycles < 200) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input bit expectDrop);
    int      cycles;
    expect_t e;
    waitResult(cycles);
    e = sbQueue.pop_front();
    checkVal({e.tag, "_lat"}, 32'(cycles), 32'(e.latency));
    checkVal({e.tag, "_res"}, curResult, e.result);
    checkVal({e.tag, "_rd"}, 32'(curRd), 32'(e.rd));
    checkVal({e.tag, "_exc"}, 32'(curExc), 32'(e.exc));
    if (expectDrop) begin
      @(posedge clk);
      @(negedge clk);
      checkVal({e.tag, "_drop"}, 32'(curValid), 32'd0);
      checkVal({e.tag, "_ready"}, 32'(curReady), 32'd1);
    end
  endtask

  task automatic watchNoValid(input string tag, input int cyclesToWatch);
    bit saw;
    saw = 1'b0;
    repeat (cyclesToWatch) begin
      @(posedge clk);
      @(negedge clk);
      if (curValid) saw = 1'b1;
    end
    checkVal(tag, 32'(saw), 32'd0);
  endtask

  initial begin
    $display("[TB] starting execute_muldiv bench");
    repeat (3) @(negedge clk);
    checkVal("rstReady", 32'(ready1), 32'd1);
    checkVal("rstValid", 32'(valid1), 32'd0);
    checkVal("rstResult", result1, 32'd0);
    checkVal("rstRd", 32'(rdOut1), 32'd0);
    checkVal("rstExc", 32'(exc1), 32'd0);
    checkVal("rstValid4", 32'(valid4), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    applyStimulus(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, "mul7xm3", 1'b1);
    checkOutput(1'b1);
    applyStimulus(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, "mulhuMax", 1'b1);
    checkOutput(1'b1);
    applyStimulus(3'd2, 32'hFFFFFFFF, 32'd2, 5'd7, "mulhsuM1x2", 1'b1);
    checkOutput(1'b1);
    applyStimulus(3'd1, 32'hFFFFFFFB, 32'd3, 5'd8, "mulhM5x3", 1'b1);
    checkOutput(1'b1);
    applyStimulus(3'd1, 32'h80000000, 32'h80000000, 5'd9, "mulhMinMin", 1'b1);
    checkOutput(1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(1, 31)),
                    "mulRand", 1'b1);
      checkOutput(1'b1);
    end

`ifdef EXECUTE_MULDIV_DIV_EN
    applyStimulus(3'd4, 32'hFFFFFFF9, 32'd2, 5'd10, "divM7by2", 1'b1);
    checkOutput(1'b1);
    applyStimulus(3'd6, 32'hFFFFFFF9, 32'd2, 5'd11, "remM7by2", 1'b1);
    checkOutput(1'b1);
    applyStimulus(3'd5, 32'd5, 32'd0, 5'd12, "divu5by0", 1'b1);
    checkOutput(1'b1);
    applyStimulus(3'd7, 32'd5, 32'd0, 5'd13, "remu5by0", 1'b1);
    checkOutput(1'b1);
    applyStimulus(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd14, "divOvf", 1'b1);
    checkOutput(1'b1);
    applyStimulus(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd15, "remOvf", 1'b1);
    checkOutput(1'b1);
    applyStimulus(3'd7, 32'd17, 32'd5, 5'd16, "remu17by5", 1'b1);
    checkOutput(1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'($urandom_range(4, 7)), $urandom, 32'($urandom_range(1, 1000)),
                    5'd17, "divRand", 1'b1);
      checkOutput(1'b1);
    end
`else
    applyStimulus(3'd4, 32'hFFFFFFF9, 32'd2, 5'd10, "divIllegal", 1'b1);
    checkOutput(1'b1);
    applyStimulus(3'd7, 32'd17, 32'd5, 5'd11, "remuIllegal", 1'b1);
    checkOutput(1'b1);
`endif

    // Result must hold through three stalled DONE cycles.
    stall = 1'b1;
    applyStimulus(3'd0, 32'd6, 32'd7, 5'd9, "stallMul", 1'b1);
    checkOutput(1'b0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      checkVal("stallHoldValid", 32'(curValid), 32'd1);
      checkVal("stallHoldRes", curResult, 32'd42);
      checkVal("stallHoldRd", 32'(curRd), 32'd9);
    end
    stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkVal("stallRelValid", 32'(curValid), 32'd0);
    checkVal("stallRelReady", 32'(curReady), 32'd1);
    checkVal("stallRelRes", curResult, 32'd0);

    // Invalidate during the tenth BUSY cycle.
    applyStimulus(3'd0, 32'd123, 32'd456, 5'd3, "flushBusy", 1'b0);
    checkVal("busyReady", 32'(curReady), 32'd0);
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkVal("busyResZero", curResult, 32'd0);
    invalidate = 1'b1;
    @(posedge clk);
    @(negedge clk);
    invalidate = 1'b0;
    checkVal("flushReady", 32'(curReady), 32'd1);
    checkVal("flushValid", 32'(curValid), 32'd0);
    watchNoValid("flushNoResult", 40);

    // Invalidate alongside a request in IDLE blocks the accept.
    opIn       = 3'd0;
    aIn        = 32'd3;
    bIn        = 32'd4;
    rdIn       = 5'd2;
    reqValid   = 1'b1;
    invalidate = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid   = 1'b0;
    invalidate = 1'b0;
    checkVal("flushIdleReady", 32'(curReady), 32'd1);
    watchNoValid("flushIdleNoResult", 40);

    // Asynchronous reset mid-operation discards the work.
    applyStimulus(3'd0, 32'd11, 32'd13, 5'd4, "resetBusy", 1'b0);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    checkVal("asyncRstReady", 32'(curReady), 32'd1);
    checkVal("asyncRstValid", 32'(curValid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    watchNoValid("resetNoResult", 40);

    // Four result bits per cycle.
    useFour = 1'b1;
    @(negedge clk);
    applyStimulus(3'd0, 32'd7, 32'hFFFFFFFD, 5'd20, "step4Mul", 1'b1);
    checkOutput(1'b1);
    applyStimulus(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21, "step4Mulhu", 1'b1);
    checkOutput(1'b1);
    applyStimulus(3'd1, $urandom, $urandom, 5'd22, "step4Rand", 1'b1);
    checkOutput(1'b1);
    useFour = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
